// File: rtl/updown_pc.sv
// Up/down counter with parallel load, selectable wrap or saturate behaviour,
// registered terminal-count pulse and saturation-refusal flag.
module updown_pc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] qout,
    output logic [WIDTH-1:0] qnout,
    output logic             tc,
    output logic             blocked
);

    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] Zero    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             blocked_q, blocked_d;

    logic             at_edge;     // a step from here in this direction would wrap
    logic             near_edge;   // a step from here lands exactly on the boundary
    logic [WIDTH-1:0] stepped;

    always_comb begin
        at_edge   = up ? (cnt_q == AllOnes) : (cnt_q == Zero);
        near_edge = up ? (cnt_q == (AllOnes - One)) : (cnt_q == One);
        stepped   = up ? (cnt_q + One) : (cnt_q - One);
    end

    always_comb begin
        cnt_d     = cnt_q;
        tc_d      = 1'b0;
        blocked_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (at_edge && sat) begin
                blocked_d = 1'b1;
            end else begin
                cnt_d = stepped;
                // Wrap mode pulses on the wrap itself; saturate mode on reaching the rail.
                tc_d  = sat ? near_edge : at_edge;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= Zero;
            tc_q      <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            blocked_q <= blocked_d;
        end
    end

    assign qout    = cnt_q;
    assign qnout   = ~cnt_q;
    assign tc      = tc_q;
    assign blocked = blocked_q;

endmodule
